// File: rtl/gamepad_scanner.sv
// -----------------------------------------------------------------------------
// gamepad_scanner
//
// Scans a Mega Drive style 3-button pad on six active-low lines. It drives
// pad_sel high then low, samples each phase after a settle time, assembles
// an 8-bit button vector and debounces it across consecutive scans.
//
// Optional feature macro: GAMEPAD_REPEAT_EN
//   Defined   : direction bits [3:0] auto-repeat on btn_pressed while held.
//   Undefined : btn_pressed fires only on 0->1 edges; REPEAT_* are ignored.
//
// Ports:
//   CLOCK_50     in   system clock
//   rst_n        in   asynchronous active-low reset
//   pad_in[5:0]  in   raw pad lines, active-low, asynchronous
//   pad_sel      out  pad select line (high except during the low phase)
//   buttons[7:0] out  debounced buttons, active-high
//                     {Start, C, B, A, Right, Left, Down, Up}
//   btn_pressed  out  one-cycle press (and repeat) pulses
//   scan_valid   out  one-cycle pulse in the COMMIT cycle of every scan
//   pad_present  out  pad detected on the last completed scan
// -----------------------------------------------------------------------------
module gamepad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int SETTLE_CYCLES  = 250,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_DELAY   = 300,
    parameter int REPEAT_RATE    = 100
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [5:0] pad_in,
    output logic       pad_sel,
    output logic [7:0] buttons,
    output logic [7:0] btn_pressed,
    output logic       scan_valid,
    output logic       pad_present
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEL_HI,
        S_SEL_LO,
        S_COMMIT
    } state_t;

    // One phase counter serves both the idle wait and the settle phases.
    localparam int CNT_MAX = (SCAN_DIV > SETTLE_CYCLES) ? SCAN_DIV : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SCANS);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_pad_sel_nxt;
    logic             w_scan_valid_nxt;
    logic             r_pad_sel;
    logic             r_scan_valid;

    logic [5:0]       r_sync1;
    logic [5:0]       r_sync2;
    logic [5:0]       w_pad;
    logic [5:0]       r_hi;
    logic [5:2]       r_lo;     // lo[1:0] duplicates Up/Down from the high phase

    logic             w_present;
    logic [7:0]       w_sample;
    logic [DEB_W-1:0] w_stable_nxt;
    logic             w_update;
    logic [7:0]       w_buttons_nxt;
    logic [7:0]       w_pulse;

    logic [7:0]       r_last_sample;
    logic [DEB_W-1:0] r_stable;
    logic [7:0]       r_buttons;
    logic [7:0]       r_pressed;
    logic             r_present;

    // ------------------------------------------------------------------
    // Input synchronizer. Lines idle high, so reset to 1 to avoid a
    // phantom all-pressed sample right after reset.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= pad_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pad = ~r_sync2;

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pad_sel    <= 1'b1;
            r_scan_valid <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_pad_sel    <= w_pad_sel_nxt;
            r_scan_valid <= w_scan_valid_nxt;
        end
    end

    // Outputs are decoded from the next state and registered, so pad_sel
    // leaves on a clean flop edge aligned with the state change.
    // NOTE: every signal gets a default before the case so no path
    // leaves it unassigned (which would infer a latch).
    always_comb begin
        w_next_state     = r_state;
        w_pad_sel_nxt    = 1'b1;
        w_scan_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE:   if (r_cnt == IDLE_LAST)   w_next_state = S_SEL_HI;
            S_SEL_HI: if (r_cnt == SETTLE_LAST) w_next_state = S_SEL_LO;
            S_SEL_LO: if (r_cnt == SETTLE_LAST) w_next_state = S_COMMIT;
            default:                            w_next_state = S_IDLE;
        endcase
        if (w_next_state == S_SEL_LO) w_pad_sel_nxt    = 1'b0;
        if (w_next_state == S_COMMIT) w_scan_valid_nxt = 1'b1;
    end

    // Phase counter restarts on every state change; capture happens on the
    // last settle cycle, when the synchronizer has long since caught up.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_next_state != r_state) r_cnt <= '0;
            else                         r_cnt <= r_cnt + 1'b1;
            if (r_state == S_SEL_HI && r_cnt == SETTLE_LAST) r_hi <= w_pad;
            if (r_state == S_SEL_LO && r_cnt == SETTLE_LAST) r_lo <= w_pad[5:2];
        end
    end

    // ------------------------------------------------------------------
    // Assembly and debounce (only consumed in COMMIT)
    // ------------------------------------------------------------------
    // A 3-button pad grounds Left/Right while select is low.
    assign w_present = r_lo[2] & r_lo[3];
    assign w_sample  = w_present ? {r_lo[5], r_hi[5], r_hi[4], r_lo[4],
                                    r_hi[3], r_hi[2], r_hi[1], r_hi[0]} : 8'h00;

    assign w_stable_nxt  = (w_sample != r_last_sample) ? DEB_W'(1) :
                           (r_stable == DEB_MAX)       ? DEB_MAX   :
                                                         r_stable + 1'b1;
    assign w_update      = (w_stable_nxt == DEB_MAX) && (w_sample != r_buttons);
    assign w_buttons_nxt = w_update ? w_sample : r_buttons;

`ifdef GAMEPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [3:0][REP_W-1:0] r_rep_cnt;
    logic [3:0][REP_W-1:0] w_rep_cnt_nxt;
    logic [3:0]            r_rep_on;    // first repeat already fired
    logic [3:0]            w_rep_on_nxt;
    logic [3:0]            w_repeat;

    // A bit counts only while it was set before and stays set after this
    // commit; a fresh press, release or absent pad restarts it.
    always_comb begin
        w_repeat      = '0;
        w_rep_cnt_nxt = r_rep_cnt;
        w_rep_on_nxt  = r_rep_on;
        for (int i = 0; i < 4; i++) begin
            if (r_buttons[i] && w_buttons_nxt[i] && w_present) begin
                if (r_rep_cnt[i] == (r_rep_on[i] ? REP_RATE_LAST : REP_DELAY_LAST)) begin
                    w_repeat[i]      = 1'b1;
                    w_rep_cnt_nxt[i] = '0;
                    w_rep_on_nxt[i]  = 1'b1;
                end else begin
                    w_rep_cnt_nxt[i] = r_rep_cnt[i] + 1'b1;
                end
            end else begin
                w_rep_cnt_nxt[i] = '0;
                w_rep_on_nxt[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt <= '0;
            r_rep_on  <= '0;
        end else if (r_state == S_COMMIT) begin
            r_rep_cnt <= w_rep_cnt_nxt;
            r_rep_on  <= w_rep_on_nxt;
        end
    end

    assign w_pulse = (w_update ? (w_sample & ~r_buttons) : 8'h00) | {4'h0, w_repeat};
`else
    assign w_pulse = w_update ? (w_sample & ~r_buttons) : 8'h00;
`endif

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sample <= '0;
            r_stable      <= '0;
            r_buttons     <= '0;
            r_pressed     <= '0;
            r_present     <= 1'b0;
        end else begin
            r_pressed <= '0;
            if (r_state == S_COMMIT) begin
                r_last_sample <= w_sample;
                r_stable      <= w_stable_nxt;
                r_buttons     <= w_buttons_nxt;
                r_pressed     <= w_pulse;
                r_present     <= w_present;
            end
        end
    end

    assign pad_sel     = r_pad_sel;
    assign scan_valid  = r_scan_valid;
    assign buttons     = r_buttons;
    assign btn_pressed = r_pressed;
    assign pad_present = r_present;

endmodule

// File: tb/tb_gamepad_scanner.sv
// -----------------------------------------------------------------------------
// tb_gamepad_scanner
//
// Directed bench for gamepad_scanner with SCAN_DIV=16, SETTLE_CYCLES=4,
// DEBOUNCE_SCANS=3, REPEAT_DELAY=4, REPEAT_RATE=2. A behavioural 3-button
// pad answers pad_sel combinationally from the buttons the bench holds.
// -----------------------------------------------------------------------------
module tb_gamepad_scanner;

    localparam int PERIOD = 25;   // 16 + 2*4 + 1

`ifdef GAMEPAD_REPEAT_EN
    localparam bit REPEAT_BUILD = 1'b1;
`else
    localparam bit REPEAT_BUILD = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       rst_n    = 1'b0;
    logic [5:0] pad_in;
    logic       pad_sel;
    logic [7:0] buttons;
    logic [7:0] btn_pressed;
    logic       scan_valid;
    logic       pad_present;

    logic       pad_connected = 1'b0;
    logic [7:0] pad_held      = 8'h00;   // {Start, C, B, A, R, L, D, U}

    int vectors        = 0;
    int miscompares    = 0;
    int pressed_cycles = 0;
    int bad_timing     = 0;
    logic prev_sv      = 1'b0;

    gamepad_scanner #(
        .SCAN_DIV      (16),
        .SETTLE_CYCLES (4),
        .DEBOUNCE_SCANS(3),
        .REPEAT_DELAY  (4),
        .REPEAT_RATE   (2)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .pad_in     (pad_in),
        .pad_sel    (pad_sel),
        .buttons    (buttons),
        .btn_pressed(btn_pressed),
        .scan_valid (scan_valid),
        .pad_present(pad_present)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Pad model: select high -> {C,B,R,L,D,U}; select low -> {Start,A,gnd,gnd,D,U}.
    assign pad_in = !pad_connected ? 6'h3F :
                    pad_sel ? ~{pad_held[6], pad_held[5], pad_held[3], pad_held[2], pad_held[1], pad_held[0]} :
                              ~{pad_held[7], pad_held[4], 2'b11, pad_held[1], pad_held[0]};

    // Any press pulse must sit in the cycle right after scan_valid.
    always @(negedge CLOCK_50) begin
        if (!rst_n) begin
            prev_sv <= 1'b0;
        end else begin
            if (btn_pressed != 8'h00) begin
                pressed_cycles <= pressed_cycles + 1;
                if (!prev_sv) bad_timing <= bad_timing + 1;
            end
            prev_sv <= scan_valid;
        end
    end

    // Returns at the negedge of the cycle after COMMIT.
    task automatic wait_commit(input string tag);
        int n = 0;
        while (scan_valid !== 1'b1 && n < 4 * PERIOD) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (scan_valid !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scan_valid timeout, got %b want 1", tag, scan_valid);
        end
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        bit exp_sel, exp_sv;
        int ph;
        pad_connected = 1'b0;
        pad_held      = 8'h00;
        rst_n         = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        vectors += 5;
        if (pad_sel !== 1'b1) begin miscompares++; $display("FAIL rst_pad_sel: got %b want 1", pad_sel); end
        if (buttons !== 8'h00) begin miscompares++; $display("FAIL rst_buttons: got %h want 00", buttons); end
        if (btn_pressed !== 8'h00) begin miscompares++; $display("FAIL rst_pressed: got %h want 00", btn_pressed); end
        if (scan_valid !== 1'b0) begin miscompares++; $display("FAIL rst_scan_valid: got %b want 0", scan_valid); end
        if (pad_present !== 1'b0) begin miscompares++; $display("FAIL rst_present: got %b want 0", pad_present); end
        rst_n = 1'b1;
        // k counts rising edges since release: 20 high, 4 low, COMMIT at 24.
        for (int k = 1; k <= 3 * PERIOD; k++) begin
            @(negedge CLOCK_50);
            ph      = k % PERIOD;
            exp_sel = !(ph >= 20 && ph <= 23);
            exp_sv  = (ph == 24);
            vectors += 2;
            if (pad_sel !== exp_sel) begin miscompares++; $display("FAIL idle_pad_sel k=%0d: got %b want %b", k, pad_sel, exp_sel); end
            if (scan_valid !== exp_sv) begin miscompares++; $display("FAIL idle_scan_valid k=%0d: got %b want %b", k, scan_valid, exp_sv); end
        end
        vectors += 2;
        if (buttons !== 8'h00) begin miscompares++; $display("FAIL idle_buttons: got %h want 00", buttons); end
        if (pad_present !== 1'b0) begin miscompares++; $display("FAIL idle_present: got %b want 0", pad_present); end
    endtask

    task automatic test_pad_present();
        int pc;
        pad_connected = 1'b1;
        pad_held      = 8'h00;
        wait_commit("present_1");
        pc = pressed_cycles;
        vectors += 2;
        if (pad_present !== 1'b1) begin miscompares++; $display("FAIL present_first: got %b want 1", pad_present); end
        if (buttons !== 8'h00) begin miscompares++; $display("FAIL present_buttons: got %h want 00", buttons); end
        repeat (3) wait_commit("present_n");
        vectors += 3;
        if (pad_present !== 1'b1) begin miscompares++; $display("FAIL present_hold: got %b want 1", pad_present); end
        if (buttons !== 8'h00) begin miscompares++; $display("FAIL present_buttons_hold: got %h want 00", buttons); end
        if (pressed_cycles !== pc) begin miscompares++; $display("FAIL present_no_pulse: got %0d pulses want 0", pressed_cycles - pc); end
    endtask

    task automatic test_press_a();
        logic [7:0] exp;
        pad_held = 8'h10;
        for (int s = 1; s <= 3; s++) begin
            wait_commit("press_a");
            exp = (s == 3) ? 8'h10 : 8'h00;
            vectors += 2;
            if (buttons !== exp) begin miscompares++; $display("FAIL press_a_buttons s=%0d: got %h want %h", s, buttons, exp); end
            if (btn_pressed !== exp) begin miscompares++; $display("FAIL press_a_pulse s=%0d: got %h want %h", s, btn_pressed, exp); end
        end
        @(negedge CLOCK_50);
        vectors++;
        if (btn_pressed !== 8'h00) begin miscompares++; $display("FAIL press_a_pulse_width: got %h want 00", btn_pressed); end
        pad_held = 8'h00;
        for (int s = 1; s <= 3; s++) begin
            wait_commit("release_a");
            exp = (s == 3) ? 8'h00 : 8'h10;
            vectors += 2;
            if (buttons !== exp) begin miscompares++; $display("FAIL release_a_buttons s=%0d: got %h want %h", s, buttons, exp); end
            if (btn_pressed !== 8'h00) begin miscompares++; $display("FAIL release_a_pulse s=%0d: got %h want 00", s, btn_pressed); end
        end
    endtask

    task automatic test_glitch();
        int pc;
        pc = pressed_cycles;
        for (int s = 1; s <= 5; s++) begin
            pad_held = (s <= 2) ? 8'h01 : 8'h00;
            wait_commit("glitch");
            vectors++;
            if (buttons !== 8'h00) begin miscompares++; $display("FAIL glitch_buttons s=%0d: got %h want 00", s, buttons); end
        end
        vectors++;
        if (pressed_cycles !== pc) begin miscompares++; $display("FAIL glitch_no_pulse: got %0d pulses want 0", pressed_cycles - pc); end
    endtask

    task automatic test_unplug();
        int pc;
        logic [7:0] exp;
        pad_held = 8'h88;
        repeat (3) wait_commit("unplug_press");
        vectors += 2;
        if (buttons !== 8'h88) begin miscompares++; $display("FAIL unplug_held: got %h want 88", buttons); end
        if (btn_pressed !== 8'h88) begin miscompares++; $display("FAIL unplug_press_pulse: got %h want 88", btn_pressed); end
        @(negedge CLOCK_50);
        pc = pressed_cycles;
        pad_connected = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            wait_commit("unplug");
            exp = (s == 3) ? 8'h00 : 8'h88;
            vectors += 2;
            if (pad_present !== 1'b0) begin miscompares++; $display("FAIL unplug_present s=%0d: got %b want 0", s, pad_present); end
            if (buttons !== exp) begin miscompares++; $display("FAIL unplug_buttons s=%0d: got %h want %h", s, buttons, exp); end
        end
        @(negedge CLOCK_50);
        vectors++;
        if (pressed_cycles !== pc) begin miscompares++; $display("FAIL unplug_no_pulse: got %0d pulses want 0", pressed_cycles - pc); end
        pad_held      = 8'h00;
        pad_connected = 1'b1;
        repeat (3) wait_commit("replug");
    endtask

    // Left: held scans 1..12, edge at 3, repeats at 7, 9, 11 and 13 (bit is
    // still debounced-held in scan 13). C: single edge at scan 3 only.
    task automatic test_repeat();
        logic [7:0] exp_btn, exp_pulse;
        for (int s = 1; s <= 15; s++) begin
            pad_held = (s <= 12) ? 8'h04 : 8'h00;
            wait_commit("repeat_left");
            exp_btn   = (s >= 3 && s <= 14) ? 8'h04 : 8'h00;
            exp_pulse = (s == 3) ? 8'h04 : 8'h00;
            if (REPEAT_BUILD && (s == 7 || s == 9 || s == 11 || s == 13)) exp_pulse = 8'h04;
            vectors += 2;
            if (buttons !== exp_btn) begin miscompares++; $display("FAIL left_buttons s=%0d: got %h want %h", s, buttons, exp_btn); end
            if (btn_pressed !== exp_pulse) begin miscompares++; $display("FAIL left_pulse s=%0d: got %h want %h", s, btn_pressed, exp_pulse); end
        end
        for (int s = 1; s <= 13; s++) begin
            pad_held = (s <= 10) ? 8'h40 : 8'h00;
            wait_commit("repeat_c");
            exp_btn   = (s >= 3 && s <= 12) ? 8'h40 : 8'h00;
            exp_pulse = (s == 3) ? 8'h40 : 8'h00;
            vectors += 2;
            if (buttons !== exp_btn) begin miscompares++; $display("FAIL c_buttons s=%0d: got %h want %h", s, buttons, exp_btn); end
            if (btn_pressed !== exp_pulse) begin miscompares++; $display("FAIL c_pulse s=%0d: got %h want %h", s, btn_pressed, exp_pulse); end
        end
    endtask

    task automatic test_reset_abort();
        int k;
        pad_held = 8'h10;
        repeat (3) wait_commit("abort_press");
        vectors++;
        if (buttons !== 8'h10) begin miscompares++; $display("FAIL abort_pre_buttons: got %h want 10", buttons); end
        repeat (18) @(negedge CLOCK_50);   // inside SEL_HI
        rst_n = 1'b0;
        @(negedge CLOCK_50);
        vectors += 4;
        if (pad_sel !== 1'b1) begin miscompares++; $display("FAIL abort_pad_sel: got %b want 1", pad_sel); end
        if (buttons !== 8'h00) begin miscompares++; $display("FAIL abort_buttons: got %h want 00", buttons); end
        if (pad_present !== 1'b0) begin miscompares++; $display("FAIL abort_present: got %b want 0", pad_present); end
        if (scan_valid !== 1'b0) begin miscompares++; $display("FAIL abort_scan_valid: got %b want 0", scan_valid); end
        rst_n = 1'b1;
        k = 0;
        while (scan_valid !== 1'b1 && k < 4 * PERIOD) begin
            @(negedge CLOCK_50);
            k++;
        end
        vectors++;
        if (k !== PERIOD - 1) begin miscompares++; $display("FAIL abort_first_scan: got edge %0d want %0d", k, PERIOD - 1); end
        @(negedge CLOCK_50);
        vectors += 2;
        if (pad_present !== 1'b1) begin miscompares++; $display("FAIL abort_present_after: got %b want 1", pad_present); end
        if (buttons !== 8'h00) begin miscompares++; $display("FAIL abort_buttons_after: got %h want 00", buttons); end
    endtask

    task automatic test_pulse_timing();
        vectors++;
        if (bad_timing !== 0) begin miscompares++; $display("FAIL pulse_timing: got %0d stray pulse cycles want 0", bad_timing); end
    endtask

    initial begin
        test_reset();
        test_pad_present();
        test_press_a();
        test_glitch();
        test_unplug();
        test_repeat();
        test_reset_abort();
        test_pulse_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
